dac_playback_ctrl: RTL and testbench
====================================

// Module: dac_playback_ctrl
// PURPOSE
//  Sequences the DDR->RF DAC playback path: latches a playback config, flushes the path, then drives
//  read_start/start_address/cap_size once per segment for N segments, repeated for a loop count
//  (0 = forever). Segment completion is taken from the path's run_cycles counter. Aborts on mm2s
//  error, stop request or watchdog timeout. Sits in the pl_clk domain, beside the DAC data path.
// PARAMETERS
//  SEG_W      4   width of segment count/index (max 15 segments)
//  LOOP_W     16  width of loop count; 0 = infinite
//  RST_CYC    16  cycles read_reset is held high per flush (>=2)
//  WDOG_W     24  watchdog counter width; a segment taking 2^WDOG_W-1 cycles aborts
// PORTS
//  pl_clk          in   1       clock (datamover clock); all logic single-domain
//  pl_rst          in   1       synchronous reset, active-high
//  cfg_start       in   1       1-cycle pulse: latch cfg_*, begin playback (ignored unless IDLE/DONE/ERROR)
//  cfg_stop        in   1       1-cycle pulse: abort playback, flush, return to IDLE
//  cfg_base_addr   in   32      DDR byte address of segment 0
//  cfg_seg_size    in   32      bytes per segment (driven to cap_size)
//  cfg_num_segs    in   SEG_W   segments per loop, must be >=1
//  cfg_loops       in   LOOP_W  loop repetitions, 0 = infinite
//  run_cycles      in   8       completed-pass counter from data path
//  read_mm2s_err   in   1       datamover error from data path (level)
//  read_start      out  1       1-cycle start pulse to data path
//  read_reset      out  1       path flush, held RST_CYC cycles
//  start_address   out  32      segment address, stable from ISSUE until next ISSUE
//  cap_size        out  32      latched cfg_seg_size
//  busy            out  1       high in any state except IDLE/DONE/ERROR
//  done            out  1       1-cycle pulse when the final loop completes
//  err             out  1       sticky; set on entering ERROR, cleared by accepted cfg_start or pl_rst
//  err_code        out  2       0 none, 1 mm2s, 2 watchdog, 3 bad config
//  seg_idx         out  SEG_W   current segment index
//  loop_idx        out  LOOP_W  completed loops (wraps modulo 2^LOOP_W in infinite mode)
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; start_address/cap_size 0; run_cycles snapshot <= run_cycles.
//  States: IDLE, FLUSH, ISSUE, WAIT, NEXT, DONE, ABORT, ERROR.
//  IDLE/DONE/ERROR + cfg_start: latch cfg; clear err/err_code/seg_idx/loop_idx; addr<=cfg_base_addr;
//   if cfg_num_segs==0 or cfg_seg_size==0 -> ERROR code 3 next cycle, else FLUSH.
//  FLUSH: read_reset=1 for exactly RST_CYC cycles, then ISSUE. Snapshot run_cycles on exit.
//  ISSUE: read_start=1 one cycle (start_address=addr valid same cycle); clear watchdog -> WAIT.
//  WAIT: completion = run_cycles != snapshot (inequality, so 8-bit wrap is harmless); on completion
//   update snapshot -> NEXT. Watchdog increments each cycle; all-ones -> ABORT with code 2.
//  NEXT (1 cycle): if seg_idx==num_segs-1: seg_idx<=0, addr<=base, loop_idx++; if loops!=0 and
//   loop_idx+1==loops -> DONE (done pulse on entry) else ISSUE. Otherwise seg_idx++, addr+=seg_size
//   (32-bit modulo add, wraps silently), -> ISSUE. No flush between segments.
//  read_mm2s_err high in ISSUE/WAIT/NEXT -> ABORT code 1. ABORT: read_reset RST_CYC cycles -> ERROR,
//   err=1 on ERROR entry. read_start never asserted in FLUSH/ABORT/ERROR.
//  cfg_stop in any busy state: FLUSH-like RST_CYC read_reset then IDLE; no err, no done.
//  Priority same cycle: pl_rst > cfg_stop > read_mm2s_err > watchdog > completion. cfg_start while
//   busy ignored. cfg_stop in IDLE/DONE/ERROR ignored (err stays).
//  Latency: cfg_start -> read_start = RST_CYC+2 cycles; completion -> next read_start = 2 cycles.
//  Config inputs not sampled after acceptance; changing them mid-run has no effect.
// TESTING
//  1 base=0x1000_0000, seg=0x4000, segs=3, loops=2; bump run_cycles after each start -> addresses
//    0x1000_0000,0x1000_4000,0x1000_8000 twice, 6 read_start pulses, one done, busy low after.
//  2 segs=1, loops=0, run_cycles counts 250..5 (wrap) -> restarts every completion, never done,
//    loop_idx increments per pass; cfg_stop -> read_reset 16 cycles then IDLE, err=0.
//  3 read_mm2s_err pulsed in WAIT of segment 1 -> read_reset 16 cycles, err=1, err_code=1,
//    no further read_start; next cfg_start clears err.
//  4 cfg_num_segs=0 or cfg_seg_size=0 -> ERROR code 3, read_start and read_reset never asserted.
//  5 base=0xFFFF_C000, seg=0x4000, segs=2 -> second address 0x0000_0000 (wrap).
//  6 WDOG_W=8, run_cycles frozen -> ABORT after 255 WAIT cycles, err_code=2; cfg_stop and completion
//    in same cycle -> stop wins, no extra read_start.

Source files
------------

// File: rtl/dac_playback_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : dac_playback_ctrl_if
// Description : Bundle of the configuration, data-path status and playback
//               control signals around dac_playback_ctrl.
//               master : host/data-path side (drives cfg_*, run_cycles,
//                        read_mm2s_err; observes the controller outputs)
//               slave  : the playback controller itself
// Revision    : 1.0 - initial release
// ============================================================================
interface dac_playback_ctrl_if #(
  parameter int SEG_W  = 4,
  parameter int LOOP_W = 16
);
  // host configuration
  logic              cfg_start;
  logic              cfg_stop;
  logic [31:0]       cfg_base_addr;
  logic [31:0]       cfg_seg_size;
  logic [SEG_W-1:0]  cfg_num_segs;
  logic [LOOP_W-1:0] cfg_loops;
  // data-path status
  logic [7:0]        run_cycles;
  logic              read_mm2s_err;
  // data-path control
  logic              read_start;
  logic              read_reset;
  logic [31:0]       start_address;
  logic [31:0]       cap_size;
  // status back to host
  logic              busy;
  logic              done;
  logic              err;
  logic [1:0]        err_code;
  logic [SEG_W-1:0]  seg_idx;
  logic [LOOP_W-1:0] loop_idx;

  modport master (
    output cfg_start, cfg_stop, cfg_base_addr, cfg_seg_size, cfg_num_segs, cfg_loops,
    output run_cycles, read_mm2s_err,
    input  read_start, read_reset, start_address, cap_size,
    input  busy, done, err, err_code, seg_idx, loop_idx
  );

  modport slave (
    input  cfg_start, cfg_stop, cfg_base_addr, cfg_seg_size, cfg_num_segs, cfg_loops,
    input  run_cycles, read_mm2s_err,
    output read_start, read_reset, start_address, cap_size,
    output busy, done, err, err_code, seg_idx, loop_idx
  );
endinterface
`default_nettype wire

// File: rtl/dac_playback_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dac_playback_ctrl
// Description : Sequences DDR->RF DAC playback. Latches a config, flushes the
//               data path, then issues one read_start per segment for
//               cfg_num_segs segments, repeated cfg_loops times (0 = forever).
//               Segment completion is any change of the path's run_cycles
//               counter. Aborts on mm2s error or watchdog expiry; cfg_stop
//               flushes and returns to idle without flagging an error.
// Ports       : pl_clk, pl_rst    clock and synchronous active-high reset
//               bus (slave)       cfg_* / run_cycles / read_mm2s_err in,
//                                 read_start / read_reset / start_address /
//                                 cap_size / busy / done / err / err_code /
//                                 seg_idx / loop_idx out
// Revision    : 1.0 - initial release
// ============================================================================
module dac_playback_ctrl #(
  parameter int SEG_W   = 4,
  parameter int LOOP_W  = 16,
  parameter int RST_CYC = 16,
  parameter int WDOG_W  = 24
) (
  input  logic               pl_clk,
  input  logic               pl_rst,
  dac_playback_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(RST_CYC + 1);
  localparam logic [CNT_W-1:0] c_flush_last = CNT_W'(RST_CYC);
  localparam logic [CNT_W-1:0] c_drain_last = CNT_W'(RST_CYC - 1);

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_FLUSH = 4'd1,
    ST_ISSUE = 4'd2,
    ST_WAIT  = 4'd3,
    ST_NEXT  = 4'd4,
    ST_DONE  = 4'd5,
    ST_ABORT = 4'd6,
    ST_ERROR = 4'd7,
    ST_STOP  = 4'd8
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [WDOG_W-1:0] r_wdog;
  logic [7:0]        r_snap;
  logic [31:0]       r_base;
  logic [31:0]       r_seg_size;
  logic [SEG_W-1:0]  r_num_segs;
  logic [LOOP_W-1:0] r_loops;
  logic [31:0]       r_addr;
  logic [SEG_W-1:0]  r_seg_idx;
  logic [LOOP_W-1:0] r_loop_idx;
  logic              r_done;
  logic              r_err;
  logic [1:0]        r_err_code;
  logic [1:0]        r_abort_code;

  logic              w_rest;
  logic              w_bad_cfg;
  logic              w_complete;
  logic [WDOG_W-1:0] w_wdog_inc;
  logic              w_wdog_exp;
  logic              w_last_seg;
  logic [LOOP_W-1:0] w_loop_inc;
  logic              w_last_loop;
  logic              w_running;
  logic              w_draining;

  assign w_rest      = (r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERROR);
  assign w_bad_cfg   = (bus.cfg_num_segs == '0) || (bus.cfg_seg_size == 32'd0);
  // Inequality rather than "greater than" keeps the 8-bit counter wrap harmless.
  assign w_complete  = (bus.run_cycles != r_snap);
  assign w_wdog_inc  = r_wdog + 1'b1;
  assign w_wdog_exp  = &w_wdog_inc;
  assign w_last_seg  = (r_seg_idx == r_num_segs - SEG_W'(1));
  assign w_loop_inc  = r_loop_idx + 1'b1;
  assign w_last_loop = (r_loops != '0) && (w_loop_inc == r_loops);
  assign w_running   = (r_state == ST_ISSUE) || (r_state == ST_WAIT) || (r_state == ST_NEXT);
  assign w_draining  = (r_state == ST_FLUSH) || (r_state == ST_ABORT) || (r_state == ST_STOP);

  // Next-state decode; order of the if-chain sets the same-cycle priority
  // stop > mm2s error > watchdog > completion.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (bus.cfg_start) w_next = w_bad_cfg ? ST_ERROR : ST_FLUSH;
      end
      // FLUSH runs RST_CYC cycles with read_reset high plus one settle cycle
      // with it released, so the run_cycles snapshot is taken after the path
      // has come out of reset.
      ST_FLUSH: begin
        if (bus.cfg_stop)              w_next = ST_STOP;
        else if (r_cnt == c_flush_last) w_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (bus.cfg_stop)           w_next = ST_STOP;
        else if (bus.read_mm2s_err) w_next = ST_ABORT;
        else                        w_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.cfg_stop)           w_next = ST_STOP;
        else if (bus.read_mm2s_err) w_next = ST_ABORT;
        else if (w_wdog_exp)        w_next = ST_ABORT;
        else if (w_complete)        w_next = ST_NEXT;
      end
      ST_NEXT: begin
        if (bus.cfg_stop)                w_next = ST_STOP;
        else if (bus.read_mm2s_err)      w_next = ST_ABORT;
        else if (w_last_seg && w_last_loop) w_next = ST_DONE;
        else                             w_next = ST_ISSUE;
      end
      ST_ABORT: begin
        if (bus.cfg_stop)               w_next = ST_STOP;
        else if (r_cnt == c_drain_last) w_next = ST_ERROR;
      end
      ST_STOP: begin
        if (r_cnt == c_drain_last) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge pl_clk) begin
    if (pl_rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_wdog       <= '0;
      r_snap       <= bus.run_cycles;
      r_base       <= 32'd0;
      r_seg_size   <= 32'd0;
      r_num_segs   <= '0;
      r_loops      <= '0;
      r_addr       <= 32'd0;
      r_seg_idx    <= '0;
      r_loop_idx   <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_err_code   <= 2'd0;
      r_abort_code <= 2'd0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == ST_NEXT) && (w_next == ST_DONE);

      if (w_next != r_state) r_cnt <= '0;
      else if (w_draining)   r_cnt <= r_cnt + 1'b1;

      if (r_state == ST_ISSUE)     r_wdog <= '0;
      else if (r_state == ST_WAIT) r_wdog <= w_wdog_inc;

      if (((r_state == ST_FLUSH) || (r_state == ST_WAIT)) &&
          ((w_next == ST_ISSUE) || (w_next == ST_NEXT)))
        r_snap <= bus.run_cycles;

      if (w_running && (w_next == ST_ABORT))
        r_abort_code <= bus.read_mm2s_err ? 2'd1 : 2'd2;

      if (w_rest && bus.cfg_start) begin
        r_base     <= bus.cfg_base_addr;
        r_seg_size <= bus.cfg_seg_size;
        r_num_segs <= bus.cfg_num_segs;
        r_loops    <= bus.cfg_loops;
        r_addr     <= bus.cfg_base_addr;
        r_seg_idx  <= '0;
        r_loop_idx <= '0;
        r_err      <= w_bad_cfg;
        r_err_code <= w_bad_cfg ? 2'd3 : 2'd0;
      end else begin
        if ((r_state == ST_NEXT) && ((w_next == ST_ISSUE) || (w_next == ST_DONE))) begin
          if (w_last_seg) begin
            r_seg_idx  <= '0;
            r_addr     <= r_base;
            r_loop_idx <= w_loop_inc;
          end else begin
            r_seg_idx  <= r_seg_idx + 1'b1;
            r_addr     <= r_addr + r_seg_size;
          end
        end
        if ((r_state == ST_ABORT) && (w_next == ST_ERROR)) begin
          r_err      <= 1'b1;
          r_err_code <= r_abort_code;
        end
      end
    end
  end

  assign bus.read_start    = (r_state == ST_ISSUE);
  assign bus.read_reset    = ((r_state == ST_FLUSH) && (r_cnt != c_flush_last)) ||
                             (r_state == ST_ABORT) || (r_state == ST_STOP);
  assign bus.start_address = r_addr;
  assign bus.cap_size      = r_seg_size;
  assign bus.busy          = !w_rest;
  assign bus.done          = r_done;
  assign bus.err           = r_err;
  assign bus.err_code      = r_err_code;
  assign bus.seg_idx       = r_seg_idx;
  assign bus.loop_idx      = r_loop_idx;

endmodule
`default_nettype wire

// File: tb/tb_dac_playback_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dac_playback_ctrl
// Description : Directed self-checking bench for dac_playback_ctrl
//               (RST_CYC=16, WDOG_W=8). Inputs driven and outputs sampled on
//               the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dac_playback_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dac_playback_ctrl_if #(.SEG_W(4), .LOOP_W(16)) bus ();

  dac_playback_ctrl #(.SEG_W(4), .LOOP_W(16), .RST_CYC(16), .WDOG_W(8)) dut (
    .pl_clk (clk),
    .pl_rst (rst),
    .bus    (bus)
  );

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Cycles until read_start is seen (0 = already high now); -1 on timeout.
  task automatic wait_start(input int limit, output int n);
    n = -1;
    for (int i = 0; i <= limit; i++) begin
      if (bus.read_start === 1'b1) begin n = i; return; end
      tick();
    end
  endtask

  // Counts read_reset / read_start / done high cycles over a window.
  task automatic watch(input int cyc, output int rr, output int rs, output int dn);
    rr = 0; rs = 0; dn = 0;
    for (int i = 0; i < cyc; i++) begin
      if (bus.read_reset === 1'b1) rr++;
      if (bus.read_start === 1'b1) rs++;
      if (bus.done === 1'b1) dn++;
      tick();
    end
  endtask

  task automatic start_cfg(input logic [31:0] base, input logic [31:0] sz,
                           input logic [3:0] segs, input logic [15:0] loops);
    bus.cfg_base_addr = base; bus.cfg_seg_size = sz;
    bus.cfg_num_segs = segs; bus.cfg_loops = loops;
    bus.cfg_start = 1'b1; tick(); bus.cfg_start = 1'b0;
  endtask

  task automatic test_reset();
    bus.cfg_start = 0; bus.cfg_stop = 0; bus.cfg_base_addr = 0; bus.cfg_seg_size = 0;
    bus.cfg_num_segs = 0; bus.cfg_loops = 0; bus.run_cycles = 0; bus.read_mm2s_err = 0;
    rst = 1'b1; repeat (3) tick(); rst = 1'b0; tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if ({bus.read_start, bus.read_reset, bus.done} !== 3'b000) begin errors++; $display("FAIL reset_ctrl: got %b want 000", {bus.read_start, bus.read_reset, bus.done}); end
    checks++; if ({bus.err, bus.err_code} !== 3'b000) begin errors++; $display("FAIL reset_err: got %b want 000", {bus.err, bus.err_code}); end
    checks++; if ({bus.start_address, bus.cap_size} !== 64'd0) begin errors++; $display("FAIL reset_addr: got %h want 0", {bus.start_address, bus.cap_size}); end
    checks++; if ({bus.seg_idx, bus.loop_idx} !== 20'd0) begin errors++; $display("FAIL reset_idx: got %h want 0", {bus.seg_idx, bus.loop_idx}); end
  endtask

  task automatic test_multi_seg();
    int n, rr, rs, dn;
    logic [31:0] exp_addr;
    start_cfg(32'h1000_0000, 32'h4000, 4'd3, 16'd2);
    checks++; if ({bus.read_reset, bus.busy} !== 2'b11) begin errors++; $display("FAIL ms_flush: got %b want 11", {bus.read_reset, bus.busy}); end
    checks++; if (bus.cap_size !== 32'h4000) begin errors++; $display("FAIL ms_cap_size: got %h want 00004000", bus.cap_size); end
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin
        wait_start(40, n);
        checks++; if (n !== 17) begin errors++; $display("FAIL ms_start_latency: got %0d want 17", n); end
      end else begin
        wait_start(10, n);
        checks++; if (n !== 2) begin errors++; $display("FAIL ms_next_latency%0d: got %0d want 2", i, n); end
      end
      exp_addr = 32'h1000_0000 + 32'h4000 * (i % 3);
      checks++; if (bus.start_address !== exp_addr) begin errors++; $display("FAIL ms_addr%0d: got %h want %h", i, bus.start_address, exp_addr); end
      checks++; if ({bus.seg_idx, bus.loop_idx} !== {4'(i % 3), 16'(i / 3)}) begin errors++; $display("FAIL ms_idx%0d: got %h want %h", i, {bus.seg_idx, bus.loop_idx}, {4'(i % 3), 16'(i / 3)}); end
      repeat (3) tick();
      bus.run_cycles = bus.run_cycles + 8'd1;
    end
    tick(); tick();
    checks++; if ({bus.done, bus.busy} !== 2'b10) begin errors++; $display("FAIL ms_done: got done,busy=%b want 10", {bus.done, bus.busy}); end
    checks++; if (bus.loop_idx !== 16'd2) begin errors++; $display("FAIL ms_loop_idx: got %0d want 2", bus.loop_idx); end
    tick();
    watch(10, rr, rs, dn);
    checks++; if ({rr, rs, dn} !== {32'd0, 32'd0, 32'd0}) begin errors++; $display("FAIL ms_after_done: got rr=%0d rs=%0d done=%0d want 0 0 0", rr, rs, dn); end
  endtask

  task automatic test_infinite_stop();
    int n, rr, rs, dn;
    bus.run_cycles = 8'd250;
    start_cfg(32'h0000_8000, 32'h100, 4'd1, 16'd0);
    wait_start(40, n);
    checks++; if (n !== 17) begin errors++; $display("FAIL inf_start_latency: got %0d want 17", n); end
    for (int p = 0; p < 11; p++) begin
      repeat (3) tick();
      bus.run_cycles = bus.run_cycles + 8'd1;
      wait_start(10, n);
      checks++; if (n !== 2 || bus.loop_idx !== 16'(p + 1) || bus.done !== 1'b0) begin errors++; $display("FAIL inf_pass%0d: got n=%0d loop=%0d done=%b want 2 %0d 0", p, n, bus.loop_idx, bus.done, p + 1); end
    end
    checks++; if (bus.start_address !== 32'h0000_8000) begin errors++; $display("FAIL inf_addr: got %h want 00008000", bus.start_address); end
    repeat (2) tick();
    bus.cfg_stop = 1'b1; tick(); bus.cfg_stop = 1'b0;
    watch(20, rr, rs, dn);
    checks++; if (rr !== 16 || rs !== 0 || dn !== 0) begin errors++; $display("FAIL inf_stop: got rr=%0d rs=%0d done=%0d want 16 0 0", rr, rs, dn); end
    checks++; if ({bus.busy, bus.err, bus.err_code} !== 4'b0000) begin errors++; $display("FAIL inf_idle: got %b want 0000", {bus.busy, bus.err, bus.err_code}); end
  endtask

  task automatic test_mm2s_err();
    int n, rr, rs, dn;
    start_cfg(32'h2000_0000, 32'h100, 4'd3, 16'd1);
    wait_start(40, n);
    repeat (3) tick();
    bus.run_cycles = bus.run_cycles + 8'd1;
    wait_start(10, n);
    checks++; if (n !== 2 || bus.start_address !== 32'h2000_0100) begin errors++; $display("FAIL mm_seg1: got n=%0d addr=%h want 2 20000100", n, bus.start_address); end
    repeat (2) tick();
    bus.read_mm2s_err = 1'b1; tick(); bus.read_mm2s_err = 1'b0;
    watch(20, rr, rs, dn);
    checks++; if (rr !== 16 || rs !== 0) begin errors++; $display("FAIL mm_abort: got rr=%0d rs=%0d want 16 0", rr, rs); end
    checks++; if ({bus.err, bus.err_code, bus.busy} !== 4'b1010) begin errors++; $display("FAIL mm_err: got err,code,busy=%b want 1010", {bus.err, bus.err_code, bus.busy}); end
    bus.cfg_stop = 1'b1; tick(); bus.cfg_stop = 1'b0; tick();
    checks++; if ({bus.err, bus.read_reset} !== 2'b10) begin errors++; $display("FAIL mm_stop_in_error: got err,rr=%b want 10", {bus.err, bus.read_reset}); end
    start_cfg(32'h2000_0000, 32'h100, 4'd3, 16'd1);
    checks++; if ({bus.err, bus.err_code, bus.busy} !== 4'b0001) begin errors++; $display("FAIL mm_clear: got err,code,busy=%b want 0001", {bus.err, bus.err_code, bus.busy}); end
    bus.cfg_stop = 1'b1; tick(); bus.cfg_stop = 1'b0;
    watch(20, rr, rs, dn);
  endtask

  task automatic test_bad_cfg();
    int rr, rs, dn;
    start_cfg(32'h4000_0000, 32'h100, 4'd0, 16'd1);
    checks++; if ({bus.err, bus.err_code, bus.busy} !== 4'b1110) begin errors++; $display("FAIL bad_segs: got err,code,busy=%b want 1110", {bus.err, bus.err_code, bus.busy}); end
    watch(25, rr, rs, dn);
    checks++; if (rr !== 0 || rs !== 0) begin errors++; $display("FAIL bad_segs_quiet: got rr=%0d rs=%0d want 0 0", rr, rs); end
    start_cfg(32'h4000_0000, 32'h0, 4'd2, 16'd1);
    checks++; if ({bus.err, bus.err_code, bus.busy} !== 4'b1110) begin errors++; $display("FAIL bad_size: got err,code,busy=%b want 1110", {bus.err, bus.err_code, bus.busy}); end
    watch(25, rr, rs, dn);
    checks++; if (rr !== 0 || rs !== 0) begin errors++; $display("FAIL bad_size_quiet: got rr=%0d rs=%0d want 0 0", rr, rs); end
  endtask

  task automatic test_addr_wrap();
    int n;
    start_cfg(32'hFFFF_C000, 32'h4000, 4'd2, 16'd1);
    wait_start(40, n);
    checks++; if (bus.start_address !== 32'hFFFF_C000) begin errors++; $display("FAIL wrap_addr0: got %h want ffffc000", bus.start_address); end
    repeat (3) tick();
    bus.run_cycles = bus.run_cycles + 8'd1;
    wait_start(10, n);
    checks++; if (n !== 2 || bus.start_address !== 32'h0000_0000) begin errors++; $display("FAIL wrap_addr1: got n=%0d addr=%h want 2 00000000", n, bus.start_address); end
    repeat (3) tick();
    bus.run_cycles = bus.run_cycles + 8'd1;
    tick(); tick();
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL wrap_done: got %b want 1", bus.done); end
  endtask

  task automatic test_watchdog_and_priority();
    int n, cnt, rr, rs, dn;
    start_cfg(32'h3000_0000, 32'h10, 4'd1, 16'd1);
    wait_start(40, n);
    cnt = -1;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (bus.read_reset === 1'b1) begin cnt = i; break; end
    end
    checks++; if (cnt !== 256) begin errors++; $display("FAIL wd_cycles: got %0d want 256", cnt); end
    watch(20, rr, rs, dn);
    checks++; if ({bus.err, bus.err_code} !== 3'b110 || rs !== 0) begin errors++; $display("FAIL wd_err: got err,code=%b rs=%0d want 110 0", {bus.err, bus.err_code}, rs); end
    start_cfg(32'h3000_0000, 32'h10, 4'd2, 16'd1);
    wait_start(40, n);
    repeat (2) tick();
    bus.run_cycles = bus.run_cycles + 8'd1;
    bus.cfg_stop = 1'b1; tick(); bus.cfg_stop = 1'b0;
    watch(25, rr, rs, dn);
    checks++; if (rr !== 16 || rs !== 0 || dn !== 0) begin errors++; $display("FAIL stop_vs_done: got rr=%0d rs=%0d done=%0d want 16 0 0", rr, rs, dn); end
    checks++; if ({bus.busy, bus.err} !== 2'b00) begin errors++; $display("FAIL stop_idle: got busy,err=%b want 00", {bus.busy, bus.err}); end
  endtask

  initial begin
    test_reset();
    test_multi_seg();
    test_infinite_stop();
    test_mm2s_err();
    test_bad_cfg();
    test_addr_wrap();
    test_watchdog_and_priority();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
